// File: rtl/carregador_instrucoes_pkg.sv
// rtl/carregador_instrucoes_pkg.sv - shared types and constants for the instruction-memory loader
package carregador_instrucoes_pkg;

    localparam int INSTR_W        = 32;
    localparam int DEFAULT_ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } state_e;

endpackage

// File: rtl/carregador_instrucoes_if.sv
// rtl/carregador_instrucoes_if.sv - host word stream plus instruction-memory write port
interface carregador_instrucoes_if
    import carregador_instrucoes_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
);

    logic               load_valid;
    logic [INSTR_W-1:0] load_data;
    logic               load_last;
    logic               load_ready;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [INSTR_W-1:0] mem_wdata;

    // host/environment side
    modport master (
        output load_valid, load_data, load_last,
        input  load_ready, mem_we, mem_waddr, mem_wdata
    );

    // loader side
    modport slave (
        input  load_valid, load_data, load_last,
        output load_ready, mem_we, mem_waddr, mem_wdata
    );

endinterface

// File: rtl/carregador_instrucoes.sv
// rtl/carregador_instrucoes.sv - clears instruction memory, streams a program in, then releases the CPU
module carregador_instrucoes
    import carregador_instrucoes_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start_i,
    input  logic                 run_start_i,
    carregador_instrucoes_if.slave bus,
    output logic                 cpu_hold_o,
    output logic                 pc_reset_o,
    output logic [ADDR_W:0]      words_loaded_o,
    output logic                 load_err_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [INSTR_W-1:0]  wdata_q, wdata_d;
    logic                xfer;

    assign xfer = (state_q == ST_LOAD) && bus.load_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (load_start_i) begin
                    state_d = ST_CLEAR;
                end else if (run_start_i) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = bus.load_data;
                    cnt_d   = cnt_q + 1'b1;
                    words_d = words_q + 1'b1;
                    // last wins over overflow when both land on the final index
                    if (bus.load_last) begin
                        cnt_d   = '0;
                        state_d = ST_RELEASE;
                    end else if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (load_start_i) begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Write port registers track the clear index so each CLEAR cycle shows its own zero write
        if (state_d == ST_CLEAR) begin
            if (state_q != ST_CLEAR) begin
                cnt_d   = '0;
                words_d = '0;
                err_d   = 1'b0;
            end
            we_d    = 1'b1;
            waddr_d = cnt_d;
            wdata_d = '0;
        end
    end

    assign bus.load_ready  = (state_q == ST_LOAD);
    assign bus.mem_we      = we_q;
    assign bus.mem_waddr   = waddr_q;
    assign bus.mem_wdata   = wdata_q;
    assign cpu_hold_o      = (state_q != ST_RUN);
    assign pc_reset_o      = (state_q == ST_RELEASE);
    assign words_loaded_o  = words_q;
    assign load_err_o      = err_q;

endmodule

// File: tb/tb_carregador_instrucoes.sv
// tb/tb_carregador_instrucoes.sv - directed vector bench for the instruction-memory loader
module tb_carregador_instrucoes;
    import carregador_instrucoes_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, sel, fill;
    logic        load_start, run_start, load_valid, load_last;
    logic [31:0] load_data;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    carregador_instrucoes_if #(.ADDR_W(8)) bus_big ();
    carregador_instrucoes_if #(.ADDR_W(3)) bus_small ();

    assign bus_big.load_valid   = load_valid & ~sel;
    assign bus_big.load_data    = load_data;
    assign bus_big.load_last    = load_last;
    assign bus_small.load_valid = load_valid & sel;
    assign bus_small.load_data  = load_data;
    assign bus_small.load_last  = load_last;

    logic       big_hold, big_pcr, big_err, small_hold, small_pcr, small_err;
    logic [8:0] big_words;
    logic [3:0] small_words;

    carregador_instrucoes #(.ADDR_W(8), .DEPTH(256)) dut_big (
        .clk(clk), .rst_n(rst_n),
        .load_start_i(load_start & ~sel), .run_start_i(run_start & ~sel),
        .bus(bus_big),
        .cpu_hold_o(big_hold), .pc_reset_o(big_pcr),
        .words_loaded_o(big_words), .load_err_o(big_err)
    );

    carregador_instrucoes #(.ADDR_W(3), .DEPTH(8)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .load_start_i(load_start & sel), .run_start_i(run_start & sel),
        .bus(bus_small),
        .cpu_hold_o(small_hold), .pc_reset_o(small_pcr),
        .words_loaded_o(small_words), .load_err_o(small_err)
    );

    logic        o_ready, o_we, o_hold, o_pcr, o_err;
    logic [7:0]  o_waddr;
    logic [31:0] o_wdata;
    logic [8:0]  o_words;

    assign o_ready = sel ? bus_small.load_ready : bus_big.load_ready;
    assign o_we    = sel ? bus_small.mem_we     : bus_big.mem_we;
    assign o_waddr = sel ? {5'b0, bus_small.mem_waddr} : bus_big.mem_waddr;
    assign o_wdata = sel ? bus_small.mem_wdata  : bus_big.mem_wdata;
    assign o_hold  = sel ? small_hold : big_hold;
    assign o_pcr   = sel ? small_pcr  : big_pcr;
    assign o_err   = sel ? small_err  : big_err;
    assign o_words = sel ? {5'b0, small_words} : big_words;

    // Memory model: starts full of ones so the clear pass is visible
    logic [31:0] mem_big [256];
    logic [31:0] mem_small [8];
    int          wr_big;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem_big[i] <= 32'hFFFF_FFFF;
            for (int i = 0; i < 8; i++) mem_small[i] <= 32'hFFFF_FFFF;
            wr_big <= 0;
        end else begin
            if (bus_big.mem_we) begin
                mem_big[bus_big.mem_waddr] <= bus_big.mem_wdata;
                wr_big <= wr_big + 1;
            end
            if (bus_small.mem_we) mem_small[bus_small.mem_waddr] <= bus_small.mem_wdata;
        end
    end

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        exp_we;
        logic [7:0]  exp_waddr;
        logic        exp_ready;
        logic        exp_hold;
        logic        exp_pcr;
        logic [8:0]  exp_words;
    } vec_t;

    vec_t vt [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_clear(input int depth);
        int bad = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("clear_entry_hold", 32'(o_hold), 32'd1);
        check("clear_entry_err", 32'(o_err), 32'd0);
        check("clear_entry_words", 32'(o_words), 32'd0);
        for (int i = 0; i < depth; i++) begin
            if (o_we !== 1'b1 || o_waddr !== 8'(i) || o_wdata !== 32'd0 ||
                o_ready !== 1'b0 || o_hold !== 1'b1) bad++;
            tick();
        end
        check("clear_bad_cycles", 32'(bad), 32'd0);
        check("clear_done_ready", 32'(o_ready), 32'd1);
        check("clear_done_we", 32'(o_we), 32'd0);
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            load_valid = vt[i].valid;
            load_data  = vt[i].data;
            load_last  = vt[i].last;
            tick();
            check($sformatf("row%0d_we", i), 32'(o_we), 32'(vt[i].exp_we));
            if (vt[i].exp_we) begin
                check($sformatf("row%0d_waddr", i), 32'(o_waddr), 32'(vt[i].exp_waddr));
                check($sformatf("row%0d_wdata", i), o_wdata, vt[i].data);
            end
            check($sformatf("row%0d_ready", i), 32'(o_ready), 32'(vt[i].exp_ready));
            check($sformatf("row%0d_hold", i), 32'(o_hold), 32'(vt[i].exp_hold));
            check($sformatf("row%0d_pcr", i), 32'(o_pcr), 32'(vt[i].exp_pcr));
            check($sformatf("row%0d_words", i), 32'(o_words), 32'(vt[i].exp_words));
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        int snap;
        // valid, data, last | we, waddr, ready, hold, pcr, words
        vt[0]  = '{1'b1, 32'h2008_0001, 1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 9'd1};
        vt[1]  = '{1'b1, 32'h2009_0002, 1'b0, 1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 9'd2};
        vt[2]  = '{1'b1, 32'h0109_5020, 1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 9'd3};
        vt[3]  = '{1'b1, 32'hAC0A_0000, 1'b1, 1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 9'd4};
        vt[4]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 9'd4};
        vt[5]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 9'd4};
        vt[6]  = '{1'b1, 32'h1111_1111, 1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 9'd1};
        vt[7]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 9'd1};
        vt[8]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 9'd1};
        vt[9]  = '{1'b1, 32'h2222_2222, 1'b0, 1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 9'd2};
        vt[10] = '{1'b1, 32'h3333_3333, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 9'd3};
        vt[11] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 9'd3};

        sel = 1'b0; fill = 1'b1;
        load_start = 1'b0; run_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = 32'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        tick();
        fill = 1'b0;
        check("rst_hold", 32'(o_hold), 32'd1);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_we", 32'(o_we), 32'd0);
        check("rst_waddr", 32'(o_waddr), 32'd0);
        check("rst_wdata", o_wdata, 32'd0);
        check("rst_pcr", 32'(o_pcr), 32'd0);
        check("rst_words", 32'(o_words), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // run_start from IDLE: release pulse, then CPU runs, no writes at all
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("run_pcr", 32'(o_pcr), 32'd1);
        check("run_hold_release", 32'(o_hold), 32'd1);
        tick();
        check("run_pcr_end", 32'(o_pcr), 32'd0);
        check("run_hold_low", 32'(o_hold), 32'd0);
        check("run_no_writes", 32'(wr_big), 32'd0);

        // four-word program loaded from RUN
        do_clear(256);
        apply_rows(0, 5);
        check("prog_mem0", mem_big[0], 32'h2008_0001);
        check("prog_mem1", mem_big[1], 32'h2009_0002);
        check("prog_mem2", mem_big[2], 32'h0109_5020);
        check("prog_mem3", mem_big[3], 32'hAC0A_0000);
        check("prog_mem4", mem_big[4], 32'd0);
        check("prog_mem255", mem_big[255], 32'd0);

        // reload with host backpressure
        do_clear(256);
        snap = wr_big;
        apply_rows(6, 11);
        check("bp_write_count", 32'(wr_big - snap), 32'd3);
        check("bp_mem0", mem_big[0], 32'h1111_1111);
        check("bp_mem1", mem_big[1], 32'h2222_2222);
        check("bp_mem2", mem_big[2], 32'h3333_3333);
        check("bp_mem3_cleared", mem_big[3], 32'd0);

        // overflow on the 8-word instance: no last
        sel = 1'b1;
        do_clear(8);
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h5000_0000 + 32'(i);
            load_last  = 1'b0;
            tick();
            check($sformatf("ovf_we%0d", i), 32'(o_we), 32'd1);
            check($sformatf("ovf_waddr%0d", i), 32'(o_waddr), 32'(i));
        end
        load_valid = 1'b0;
        check("ovf_err", 32'(o_err), 32'd1);
        check("ovf_hold", 32'(o_hold), 32'd1);
        check("ovf_pcr", 32'(o_pcr), 32'd0);
        check("ovf_ready", 32'(o_ready), 32'd0);
        check("ovf_words", 32'(o_words), 32'd8);
        tick();
        check("ovf_pcr_after", 32'(o_pcr), 32'd0);
        check("ovf_hold_after", 32'(o_hold), 32'd1);
        check("ovf_mem7", mem_small[7], 32'h5000_0007);

        // last coinciding with the final index completes normally
        do_clear(8);
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h6000_0000 + 32'(i);
            load_last  = (i == 7);
            tick();
            check($sformatf("full_we%0d", i), 32'(o_we), 32'd1);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("full_err", 32'(o_err), 32'd0);
        check("full_pcr", 32'(o_pcr), 32'd1);
        check("full_words", 32'(o_words), 32'd8);
        tick();
        check("full_hold_low", 32'(o_hold), 32'd0);
        check("full_mem7", mem_small[7], 32'h6000_0007);

        // asynchronous reset in the middle of a load
        sel = 1'b0;
        do_clear(256);
        load_valid = 1'b1;
        load_data  = 32'hCAFE_0001;
        tick();
        load_data  = 32'hCAFE_0002;
        tick();
        check("mid_words_before", 32'(o_words), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_hold", 32'(o_hold), 32'd1);
        check("mid_ready", 32'(o_ready), 32'd0);
        check("mid_we", 32'(o_we), 32'd0);
        check("mid_waddr", 32'(o_waddr), 32'd0);
        check("mid_words", 32'(o_words), 32'd0);
        check("mid_pcr", 32'(o_pcr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_idle_ready", 32'(o_ready), 32'd0);
        check("mid_idle_we", 32'(o_we), 32'd0);
        load_valid = 1'b0;
        run_start  = 1'b1;
        tick();
        run_start  = 1'b0;
        check("mid_idle_run_pcr", 32'(o_pcr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
